stopwatch_ctrl: RTL

//  Run/pause/clear controller for an MM:SS stopwatch built from cascaded BCD digit counters.

---
 rtl/stopwatch_pkg.sv | 35 +++
 rtl/stopwatch_ctrl_bcd_digit_cnt.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: state encoding, digit limits
// and the BCD next-value helper used to capture post-edge digits for lap.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE
    } state_t;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 5;

    localparam int ONES_W = 4;
    localparam int TENS_W = 3;

    // Value a digit counter will hold after the current edge (no clear in RUN).
    function automatic logic [3:0] bcd_next(input logic [3:0] q,
                                            input logic [3:0] max,
                                            input logic       inc);
        if (!inc)
            return q;
        else if (q == max)
            return 4'd0;
        else
            return q + 4'd1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_cnt.sv
// Single BCD digit counter wrapping MAX -> 0, with a combinational carry
// that fires on the increment that wraps.
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] QMAX = W'(MAX);

    always_ff @(posedge clk) begin
        if (reset || clr)
            q <= '0;
        else if (inc)
            q <= (q == QMAX) ? '0 : q + W'(1);
    end

    assign carry = inc && (q == QMAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller: prescaled 1 Hz tick gated by an
// IDLE/RUN/PAUSE FSM, cascaded BCD MM:SS counters and a lap display hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       paused,
    output logic       lap_hold,
    output logic       rollover
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t              state;
    state_t              state_nxt;
    logic                clear_eff;
    logic                tick;
    logic [PW-1:0]       presc;

    logic [TENS_W-1:0]   min_tens_live, sec_tens_live;
    logic [ONES_W-1:0]   min_ones_live, sec_ones_live;
    logic [TENS_W-1:0]   min_tens_nxt, sec_tens_nxt;
    logic [ONES_W-1:0]   min_ones_nxt, sec_ones_nxt;
    logic                c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

    logic [TENS_W-1:0]   min_tens_lap, sec_tens_lap;
    logic [ONES_W-1:0]   min_ones_lap, sec_ones_lap;
    logic                lap_hold_r, running_r, paused_r, rollover_r;

    // clear is only honoured outside RUN; in RUN a coincident start_stop wins
    always_comb begin
        state_nxt = state;
        clear_eff = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear)
                    clear_eff = 1'b1;
                else if (start_stop)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (start_stop)
                    state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (clear) begin
                    clear_eff = 1'b1;
                    state_nxt = S_IDLE;
                end else if (start_stop) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    assign tick = (state == S_RUN) && (presc == PRESC_LAST);

    // Prescaler holds in PAUSE so a resume continues the partial second
    always_ff @(posedge clk) begin
        if (reset || clear_eff)
            presc <= '0;
        else if (state == S_RUN)
            presc <= tick ? '0 : presc + PW'(1);
    end

    bcd_digit_cnt #(.MAX(SEC_ONES_MAX), .W(ONES_W)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(clear_eff), .inc(tick),
        .q(sec_ones_live), .carry(c_sec_ones)
    );

    bcd_digit_cnt #(.MAX(SEC_TENS_MAX), .W(TENS_W)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clear_eff), .inc(c_sec_ones),
        .q(sec_tens_live), .carry(c_sec_tens)
    );

    bcd_digit_cnt #(.MAX(MIN_ONES_MAX), .W(ONES_W)) u_min_ones (
        .clk(clk), .reset(reset), .clr(clear_eff), .inc(c_sec_tens),
        .q(min_ones_live), .carry(c_min_ones)
    );

    bcd_digit_cnt #(.MAX(MIN_TENS_MAX), .W(TENS_W)) u_min_tens (
        .clk(clk), .reset(reset), .clr(clear_eff), .inc(c_min_ones),
        .q(min_tens_live), .carry(c_min_tens)
    );

    // Lap captures what the live counters will hold after this edge
    assign sec_ones_nxt = bcd_next(sec_ones_live, 4'(SEC_ONES_MAX), tick);
    assign sec_tens_nxt = TENS_W'(bcd_next({1'b0, sec_tens_live}, 4'(SEC_TENS_MAX), c_sec_ones));
    assign min_ones_nxt = bcd_next(min_ones_live, 4'(MIN_ONES_MAX), c_sec_tens);
    assign min_tens_nxt = TENS_W'(bcd_next({1'b0, min_tens_live}, 4'(MIN_TENS_MAX), c_min_ones));

    always_ff @(posedge clk) begin
        if (reset || clear_eff) begin
            lap_hold_r   <= 1'b0;
            sec_ones_lap <= '0;
            sec_tens_lap <= '0;
            min_ones_lap <= '0;
            min_tens_lap <= '0;
        end else if (lap) begin
            if (state == S_RUN && !lap_hold_r) begin
                lap_hold_r   <= 1'b1;
                sec_ones_lap <= sec_ones_nxt;
                sec_tens_lap <= sec_tens_nxt;
                min_ones_lap <= min_ones_nxt;
                min_tens_lap <= min_tens_nxt;
            end else begin
                lap_hold_r   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running_r  <= 1'b0;
            paused_r   <= 1'b0;
            rollover_r <= 1'b0;
        end else begin
            running_r  <= (state_nxt == S_RUN);
            paused_r   <= (state_nxt == S_PAUSE);
            rollover_r <= c_min_tens;
        end
    end

    assign running  = running_r;
    assign paused   = paused_r;
    assign lap_hold = lap_hold_r;
    assign rollover = rollover_r;

    assign min_tens = lap_hold_r ? min_tens_lap : min_tens_live;
    assign min_ones = lap_hold_r ? min_ones_lap : min_ones_live;
    assign sec_tens = lap_hold_r ? sec_tens_lap : sec_tens_live;
    assign sec_ones = lap_hold_r ? sec_ones_lap : sec_ones_live;

endmodule
